spi_reg_write_arbiter: RTL and testbench
========================================

// Module: spi_reg_write_arbiter
// PURPOSE
//   Sole writer of the PWM/output-enable configuration register bank. Arbitrates
//   write frames from two requesters (port 0: SPI frame decoder, port 1: on-chip
//   sequencer/debug) round-robin, validates each frame, commits valid writes and
//   drives the five configuration bytes to the output and PWM blocks.
// PARAMETERS
//   NUM_REGS   5  number of implemented registers (addresses 0..NUM_REGS-1)
//   ADDR_W     7  frame address width
//   DATA_W     8  frame/register data width
//   ERR_W      8  width of saturating rejected-frame counter
// PORTS
//   clk             in   1       system clock
//   rst_n           in   1       async active-low reset
//   s0_valid        in   1       requester 0 frame valid
//   s0_ready        out  1       requester 0 frame accepted this cycle
//   s0_rw           in   1       1 = write, 0 = read
//   s0_addr         in   ADDR_W  register address
//   s0_data         in   DATA_W  write data
//   s1_valid/s1_ready/s1_rw/s1_addr/s1_data  as s0_*, requester 1
//   en_out_7_0      out  8       reg 0x00
//   en_out_15_8     out  8       reg 0x01
//   en_pwm_7_0      out  8       reg 0x02
//   en_pwm_15_8     out  8       reg 0x03
//   pwm_duty_cycle  out  8       reg 0x04
//   commit          out  1       one-cycle pulse: register written
//   last_grant      out  1       index of most recently accepted requester
//   err_count       out  ERR_W   saturating count of rejected frames
// BEHAVIOUR
//   Reset (async, rst_n low): all five registers 0x00, commit 0, err_count 0,
//   last_grant 1 (so port 0 wins first tie), FSM IDLE, holding regs cleared,
//   both ready low.
//   FSM: IDLE -> COMMIT on any handshake; COMMIT -> IDLE unconditionally.
//   IDLE: if any sx_valid, select winner: sole requester, or on tie the port
//   != last_grant. Winner's sx_ready = 1 combinationally in IDLE only; other
//   ready 0. On that edge capture rw/addr/data, last_grant <= winner.
//   COMMIT: both ready 0. If rw==1 && addr<NUM_REGS: reg[addr] <= data,
//   commit pulses 1 for this cycle's edge output. Else: frame dropped, no
//   register changes, err_count <= err_count+1 saturating at all-ones.
//   Latency: handshake at edge E0; register value visible after E1.
//   Throughput: one frame per 2 cycles; loser stays pending, served next IDLE.
//   Requesters hold valid and payload stable until ready seen; deasserting
//   valid before ready is legal (request withdrawn, no side effects).
//   Reads (rw=0) unsupported: counted as errors. Addresses >= NUM_REGS
//   (0x05..0x7F) dropped and counted; no aliasing or wrap.
//   Same-address back-to-back writes: later commit wins.
//   Reset during COMMIT: pending frame discarded, registers return to 0x00.
//   Register outputs are flops; no combinational path from inputs to them.
// STRUCTURE
//   Shared package: register address localparams (0x00..0x04), NUM_REGS,
//   FSM state encoding (IDLE, COMMIT), frame field widths.
//   Sub-module: rr_arb2 -- 2-way round-robin grant from {valid, last_grant},
//   purely combinational; FSM, holding regs, bank and counter live here.
// TESTING
//   1 Reset, s0 writes 0x04<=0x80 -> s0_ready 1 cycle, pwm_duty_cycle=0x80
//     two edges after handshake, commit 1 pulse, err_count 0.
//   2 s0 and s1 valid same cycle (0x00<=0xAA, 0x01<=0x55) held -> s0 granted
//     first, s1 next IDLE; en_out_7_0=0xAA, en_out_15_8=0x55, last_grant=1.
//   3 s1 then s0/s1 continuously valid 6 frames -> grants alternate
//     0,1,0,1..., never two consecutive grants to one port.
//   4 write addr 0x05 and 0x7F, read rw=0 addr 0x02 -> all regs unchanged,
//     no commit, err_count=3; 260 bad frames -> err_count stays 0xFF.
//   5 rst_n low in COMMIT of 0x02<=0xFF -> en_pwm_7_0=0x00, err_count 0,
//     next frame after release accepted normally.
//   6 s0 valid withdrawn while s1 holds bus in COMMIT -> s0 never acked,
//     no register change from s0 payload.

Source files
------------

// File: rtl/spi_reg_write_arbiter_pkg.sv
// Shared definitions for the PWM/output-enable configuration register writer:
// frame widths, register map, FSM encoding and frame payload.
package spi_reg_write_arbiter_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned NUM_REGS = 5;

  // Register map (index into the bank)
  localparam int unsigned REG_EN_OUT_LO = 0;
  localparam int unsigned REG_EN_OUT_HI = 1;
  localparam int unsigned REG_EN_PWM_LO = 2;
  localparam int unsigned REG_EN_PWM_HI = 3;
  localparam int unsigned REG_PWM_DUTY  = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  // A frame is committed only if it is a write to an implemented register
  function automatic logic frame_is_valid_write(frame_t f);
    return f.rw && (f.addr < ADDR_W'(NUM_REGS));
  endfunction

endpackage

// File: rtl/spi_reg_write_arbiter_if.sv
// Single-requester write-frame handshake: valid/ready plus rw/addr/data payload.
interface spi_reg_write_arbiter_if;
  import spi_reg_write_arbiter_pkg::*;

  logic              valid;
  logic              ready;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, rw, addr, data, input ready);
  modport slave  (input valid, rw, addr, data, output ready);

endinterface

// File: rtl/spi_reg_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: sole requester wins, ties go to the port that
// was not granted last.
module spi_reg_write_arbiter_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid_c,
  output logic       grant_idx_c
);

  always_comb begin
    grant_valid_c = |valid;
    grant_idx_c   = 1'b0;
    if (valid == 2'b11) begin
      grant_idx_c = ~last_grant;
    end else begin
      grant_idx_c = valid[1];
    end
  end

endmodule

// File: rtl/spi_reg_write_arbiter.sv
// Sole writer of the output-enable/PWM configuration bank: arbitrates two
// requesters, validates each accepted frame and commits it one cycle later.
module spi_reg_write_arbiter
  import spi_reg_write_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_write_arbiter_if.slave s0,
  spi_reg_write_arbiter_if.slave s1,
  output logic [DATA_W-1:0]     en_out_7_0,
  output logic [DATA_W-1:0]     en_out_15_8,
  output logic [DATA_W-1:0]     en_pwm_7_0,
  output logic [DATA_W-1:0]     en_pwm_15_8,
  output logic [DATA_W-1:0]     pwm_duty_cycle,
  output logic                  commit,
  output logic                  last_grant,
  output logic [ERR_W-1:0]      err_count
);

  state_t            state_q;
  state_t            state_d;
  frame_t            hold_q;
  frame_t            win_frame;
  logic [DATA_W-1:0] bank_q [NUM_REGS];

  logic grant_valid;
  logic grant_idx;
  logic accept;
  logic wr_en;
  logic err_inc;

  spi_reg_write_arbiter_rr_arb2 u_arb (
    .valid         ({s1.valid, s0.valid}),
    .last_grant    (last_grant),
    .grant_valid_c (grant_valid),
    .grant_idx_c   (grant_idx)
  );

  assign win_frame = grant_idx ? frame_t'{rw: s1.rw, addr: s1.addr, data: s1.data}
                               : frame_t'{rw: s0.rw, addr: s0.addr, data: s0.data};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE; commit/reject decision in COMMIT
  always_comb begin
    s0.ready = 1'b0;
    s1.ready = 1'b0;
    accept   = 1'b0;
    wr_en    = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          accept   = 1'b1;
          s0.ready = ~grant_idx;
          s1.ready = grant_idx;
        end
      end
      ST_COMMIT: begin
        if (frame_is_valid_write(hold_q)) begin
          wr_en = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Holding register, grant history, bank and rejected-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      last_grant <= 1'b1;
      commit     <= 1'b0;
      err_count  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      commit <= wr_en;
      if (accept) begin
        hold_q     <= win_frame;
        last_grant <= grant_idx;
      end
      if (err_inc && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (hold_q.addr == ADDR_W'(i))) begin
          bank_q[i] <= hold_q.data;
        end
      end
    end
  end

  assign en_out_7_0     = bank_q[REG_EN_OUT_LO];
  assign en_out_15_8    = bank_q[REG_EN_OUT_HI];
  assign en_pwm_7_0     = bank_q[REG_EN_PWM_LO];
  assign en_pwm_15_8    = bank_q[REG_EN_PWM_HI];
  assign pwm_duty_cycle = bank_q[REG_PWM_DUTY];

endmodule

// File: tb/tb_spi_reg_write_arbiter.sv
// Self-checking bench for spi_reg_write_arbiter: directed frame table,
// hand-written corner sequences and randomized traffic against a frame-level model.
module tb_spi_reg_write_arbiter;
  import spi_reg_write_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  logic [7:0] en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty_cycle;
  logic commit, last_grant;
  logic [7:0] err_count;

  spi_reg_write_arbiter_if s0_if ();
  spi_reg_write_arbiter_if s1_if ();

  spi_reg_write_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0             (s0_if.slave),
    .s1             (s1_if.slave),
    .en_out_7_0     (en_out_7_0),
    .en_out_15_8    (en_out_15_8),
    .en_pwm_7_0     (en_pwm_7_0),
    .en_pwm_15_8    (en_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .commit         (commit),
    .last_grant     (last_grant),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester drive state
  logic [1:0] drv_v;
  frame_t     drv_f [2];
  int         hs_port;

  // Frame-level reference model
  logic [7:0] m_regs [5];
  logic [7:0] m_err;
  logic       m_lg;
  logic       m_busy;
  logic       m_commit;
  frame_t     m_hold;

  typedef struct {
    int         port;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    int         idx;
    logic [7:0] val;
    logic       exp_commit;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_reg(int idx);
    case (idx)
      0: return en_out_7_0;
      1: return en_out_15_8;
      2: return en_pwm_7_0;
      3: return en_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  function automatic frame_t mk(logic rw, logic [6:0] addr, logic [7:0] data);
    frame_t f;
    f.rw = rw; f.addr = addr; f.data = data;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_err = 8'h00; m_lg = 1'b1; m_busy = 1'b0; m_commit = 1'b0; m_hold = '0;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 5; i++) check($sformatf("reg%0d", i), 32'(get_reg(i)), 32'(m_regs[i]));
    check("commit", 32'(commit), 32'(m_commit));
    check("last_grant", 32'(last_grant), 32'(m_lg));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask

  // One clock cycle: drive, check ready against the model, advance the model, check outputs
  task automatic step();
    logic [1:0] v;
    logic       hs, win;
    s0_if.valid = drv_v[0]; s0_if.rw = drv_f[0].rw; s0_if.addr = drv_f[0].addr; s0_if.data = drv_f[0].data;
    s1_if.valid = drv_v[1]; s1_if.rw = drv_f[1].rw; s1_if.addr = drv_f[1].addr; s1_if.data = drv_f[1].data;
    #1;
    v   = drv_v;
    hs  = !m_busy && (v != 2'b00);
    win = (v == 2'b11) ? ~m_lg : v[1];
    check("s0_ready", 32'(s0_if.ready), 32'(hs && !win));
    check("s1_ready", 32'(s1_if.ready), 32'(hs && win));
    hs_port  = -1;
    m_commit = 1'b0;
    if (m_busy) begin
      if (m_hold.rw && (int'(m_hold.addr) < 5)) begin
        m_regs[int'(m_hold.addr)] = m_hold.data;
        m_commit = 1'b1;
      end else if (m_err != 8'hFF) begin
        m_err = m_err + 8'd1;
      end
      m_busy = 1'b0;
    end else if (hs) begin
      m_hold  = drv_f[int'(win)];
      m_lg    = win;
      m_busy  = 1'b1;
      hs_port = int'(win);
      drv_v[int'(win)] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_v = 2'b00;
    s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_s0_ready", 32'(s0_if.ready), 32'(0));
    check("rst_s1_ready", 32'(s1_if.ready), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Present a frame on a port, wait (bounded) for acceptance, then run its commit cycle
  task automatic send(int port, frame_t f);
    logic done;
    done = 1'b0;
    drv_v[port] = 1'b1;
    drv_f[port] = f;
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      if (hs_port == port) done = 1'b1;
    end
    check("send_accepted", 32'(done), 32'(1));
    drv_v[port] = 1'b0;
    if (done) step();
  endtask

  initial begin
    int   grants [6];
    int   ng;
    logic [7:0] d;

    vecs[0] = '{0, 1'b1, 7'h04, 8'h80, 4, 8'h80, 1'b1, 8'd0};
    vecs[1] = '{1, 1'b1, 7'h00, 8'hAA, 0, 8'hAA, 1'b1, 8'd0};
    vecs[2] = '{0, 1'b1, 7'h05, 8'h11, 4, 8'h80, 1'b0, 8'd1};
    vecs[3] = '{1, 1'b1, 7'h7F, 8'h22, 0, 8'hAA, 1'b0, 8'd2};
    vecs[4] = '{0, 1'b0, 7'h02, 8'h33, 2, 8'h00, 1'b0, 8'd3};
    vecs[5] = '{0, 1'b1, 7'h03, 8'hC3, 3, 8'hC3, 1'b1, 8'd3};
    vecs[6] = '{1, 1'b1, 7'h03, 8'h3C, 3, 8'h3C, 1'b1, 8'd3};
    vecs[7] = '{0, 1'b1, 7'h01, 8'h55, 1, 8'h55, 1'b1, 8'd3};
    vecs[8] = '{1, 1'b1, 7'h02, 8'hFF, 2, 8'hFF, 1'b1, 8'd3};

    drv_f[0] = '0; drv_f[1] = '0; drv_v = 2'b00;
    s0_if.rw = 1'b0; s0_if.addr = '0; s0_if.data = '0;
    s1_if.rw = 1'b0; s1_if.addr = '0; s1_if.data = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Directed frame table
    foreach (vecs[i]) begin
      send(vecs[i].port, mk(vecs[i].rw, vecs[i].addr, vecs[i].data));
      check($sformatf("vec%0d_reg", i), 32'(get_reg(vecs[i].idx)), 32'(vecs[i].val));
      check($sformatf("vec%0d_commit", i), 32'(commit), 32'(vecs[i].exp_commit));
      check($sformatf("vec%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
    end
    step();
    check("commit_one_pulse", 32'(commit), 32'(0));

    // Both ports continuously valid: grants must alternate starting with port 0
    do_reset();
    drv_v = 2'b11;
    drv_f[0] = mk(1'b1, 7'h00, 8'hAA);
    drv_f[1] = mk(1'b1, 7'h01, 8'h55);
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      step();
      if (hs_port >= 0) begin
        grants[ng] = hs_port;
        ng++;
        drv_v[hs_port] = 1'b1;
        drv_f[hs_port] = mk(1'b1, 7'(2 + hs_port), 8'(ng));
      end
    end
    check("rr_grant_count", 32'(ng), 32'(6));
    for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    drv_v = 2'b00;
    step();
    check("rr_en_out_7_0", 32'(en_out_7_0), 32'(8'hAA));
    check("rr_en_out_15_8", 32'(en_out_15_8), 32'(8'h55));
    check("rr_last_grant", 32'(last_grant), 32'(1));

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send(i % 2, mk(i[0], (i % 3 == 0) ? 7'h7F : 7'h05, 8'(i)));
      if (i == 254) check("err_at_255", 32'(err_count), 32'(8'hFF));
    end
    check("err_saturated", 32'(err_count), 32'(8'hFF));
    check("sat_regs_untouched", 32'(en_pwm_7_0), 32'(0));

    // Reset asserted during COMMIT discards the pending frame
    do_reset();
    send(1, mk(1'b0, 7'h02, 8'h01));
    drv_v[0] = 1'b1; drv_f[0] = mk(1'b1, 7'h02, 8'hFF);
    step();
    check("rst_commit_hs", 32'(hs_port), 32'(0));
    rst_n = 1'b0;
    drv_v = 2'b00; s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rstc_en_pwm_7_0", 32'(en_pwm_7_0), 32'(0));
    check("rstc_err", 32'(err_count), 32'(0));
    check("rstc_commit", 32'(commit), 32'(0));
    check("rstc_last_grant", 32'(last_grant), 32'(1));
    rst_n = 1'b1;
    send(0, mk(1'b1, 7'h02, 8'h5A));
    check("post_rst_en_pwm_7_0", 32'(en_pwm_7_0), 32'(8'h5A));

    // Port 0 request withdrawn while port 1 is being committed
    do_reset();
    drv_v[1] = 1'b1; drv_f[1] = mk(1'b1, 7'h01, 8'h12);
    step();
    check("wd_s1_hs", 32'(hs_port), 32'(1));
    drv_v[0] = 1'b1; drv_f[0] = mk(1'b1, 7'h00, 8'h77);
    step();
    drv_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("wd_en_out_7_0", 32'(en_out_7_0), 32'(0));
    check("wd_en_out_15_8", 32'(en_out_15_8), 32'(8'h12));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!drv_v[p]) begin
          if ($urandom_range(0, 99) < 55) begin
            d = 8'($urandom);
            drv_v[p] = 1'b1;
            drv_f[p] = mk($urandom_range(0, 9) != 0,
                          ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5)), d);
          end
        end else if ($urandom_range(0, 99) < 4) begin
          drv_v[p] = 1'b0;
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
